// File: rtl/multi_debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package multi_debounce_pkg;

    // Per-channel FSM state; btn_out is 1 in PRESSED, HELD and REL.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRESSED = 3'd2,
        ST_HELD    = 3'd3,
        ST_REL     = 3'd4
    } db_state_e;

    // Default width of the stability and hold counters.
    localparam int unsigned DEFAULT_CNT_W = 16;

endpackage : multi_debounce_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, stable-count filter,
// press/release strobes and long-press detection.
module debounce_channel
    import multi_debounce_pkg::*;
#(
    parameter int unsigned CNT_W         = DEFAULT_CNT_W,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned LONG_CYCLES   = 50000,
    parameter bit          INVERT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_pulse_o,
    output logic long_held_o
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    // With a one-cycle filter ARM and REL are passed straight through.
    localparam bit               SINGLE      = (STABLE_CYCLES == 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             s_in;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hold_q;
    logic             from_held_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_pulse_q;
    logic             long_held_q;

    // Two-flop synchroniser, reset to the inactive raw level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= INVERT;
            sync2_q <= INVERT;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    assign s_in = sync2_q ^ INVERT;

    // Debounce FSM with registered level and strobes. A hold that reaches
    // the long-press threshold always lands in HELD, taking priority over
    // release progress in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            from_held_q  <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_pulse_q <= 1'b0;
            long_held_q  <= 1'b0;
        end else begin
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (s_in) begin
                        if (SINGLE) begin
                            state_q <= ST_PRESSED;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            hold_q  <= '0;
                        end else begin
                            state_q <= ST_ARM;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                ST_ARM: begin
                    if (!s_in) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= ST_PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        hold_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (hold_q == LONG_LAST) begin
                        state_q      <= ST_HELD;
                        long_pulse_q <= 1'b1;
                        long_held_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + CNT_ONE;
                        if (!s_in) begin
                            if (SINGLE) begin
                                state_q     <= ST_IDLE;
                                level_q     <= 1'b0;
                                release_q   <= 1'b1;
                                long_held_q <= 1'b0;
                                hold_q      <= '0;
                                cnt_q       <= '0;
                                from_held_q <= 1'b0;
                            end else begin
                                state_q     <= ST_REL;
                                cnt_q       <= CNT_ONE;
                                from_held_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_HELD: begin
                    if (!s_in) begin
                        if (SINGLE) begin
                            state_q     <= ST_IDLE;
                            level_q     <= 1'b0;
                            release_q   <= 1'b1;
                            long_held_q <= 1'b0;
                            hold_q      <= '0;
                            cnt_q       <= '0;
                            from_held_q <= 1'b0;
                        end else begin
                            state_q     <= ST_REL;
                            cnt_q       <= CNT_ONE;
                            from_held_q <= 1'b1;
                        end
                    end
                end
                ST_REL: begin
                    if (!from_held_q && (hold_q == LONG_LAST)) begin
                        state_q      <= ST_HELD;
                        long_pulse_q <= 1'b1;
                        long_held_q  <= 1'b1;
                        from_held_q  <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        if (!from_held_q) begin
                            hold_q <= hold_q + CNT_ONE;
                        end
                        if (s_in) begin
                            state_q <= from_held_q ? ST_HELD : ST_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_q     <= ST_IDLE;
                            level_q     <= 1'b0;
                            release_q   <= 1'b1;
                            long_held_q <= 1'b0;
                            hold_q      <= '0;
                            cnt_q       <= '0;
                            from_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_pulse_o = long_pulse_q;
    assign long_held_o  = long_held_q;

endmodule : debounce_channel

// File: rtl/multi_debounce.sv
// N-channel debouncer: one independent debounce_channel per input bit.
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned LONG_CYCLES   = 50000,
    parameter bit          INVERT        = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] long_held
);

    // One channel instance per input bit; outputs are concatenated by index.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        debounce_channel #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .INVERT        (INVERT)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .btn_i        (btn_in[gi]),
            .level_o      (btn_out[gi]),
            .press_o      (press_pulse[gi]),
            .release_o    (release_pulse[gi]),
            .long_pulse_o (long_pulse[gi]),
            .long_held_o  (long_held[gi])
        );
    end

endmodule : multi_debounce

// File: tb/tb_multi_debounce.sv
// Randomised and directed bench for multi_debounce against a run-length model.
module tb_multi_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_inv;

    logic [1:0] bo_a, pp_a, rp_a, lp_a, lh_a;
    logic [1:0] bo_b, pp_b, rp_b, lp_b, lh_b;
    logic [1:0] bo_c, pp_c, rp_c, lp_c, lh_c;

    int n_checks = 0;
    int n_errors = 0;

    assign btn_inv = ~btn_in;

    // A: main config; B: active-low inputs fed the inverted stimulus; C: one-cycle filter.
    multi_debounce #(.CHANNELS(2), .CNT_W(16), .STABLE_CYCLES(4), .LONG_CYCLES(10), .INVERT(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_out(bo_a), .press_pulse(pp_a),
        .release_pulse(rp_a), .long_pulse(lp_a), .long_held(lh_a));
    multi_debounce #(.CHANNELS(2), .CNT_W(16), .STABLE_CYCLES(4), .LONG_CYCLES(10), .INVERT(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_inv), .btn_out(bo_b), .press_pulse(pp_b),
        .release_pulse(rp_b), .long_pulse(lp_b), .long_held(lh_b));
    multi_debounce #(.CHANNELS(2), .CNT_W(16), .STABLE_CYCLES(1), .LONG_CYCLES(3), .INVERT(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_out(bo_c), .press_pulse(pp_c),
        .release_pulse(rp_c), .long_pulse(lp_c), .long_held(lh_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: config 0 = (4,10), config 1 = (1,3).
    bit m_lvl [2][2];
    bit m_lng [2][2];
    bit m_pr  [2][2];
    bit m_rl  [2][2];
    bit m_lp  [2][2];
    int m_run [2][2];
    int m_hold[2][2];
    bit h1[2];
    bit h2[2];

    function automatic int stab(input int c);
        return (c == 0) ? 4 : 1;
    endfunction

    function automatic int longc(input int c);
        return (c == 0) ? 10 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_lvl[c][ch] = 0; m_lng[c][ch] = 0; m_pr[c][ch] = 0;
                m_rl[c][ch] = 0;  m_lp[c][ch] = 0;  m_run[c][ch] = 0; m_hold[c][ch] = 0;
            end
        end
        h1[0] = 0; h1[1] = 0; h2[0] = 0; h2[1] = 0;
    endtask

    // One clock of the model: the filter sees the input sampled two edges ago.
    // run = length of the current streak of the opposite level; hold = cycles
    // spent pressed since the press strobe.
    task automatic model_step();
        bit s;
        for (int c = 0; c < 2; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                s = h2[ch];
                m_pr[c][ch] = 0; m_rl[c][ch] = 0; m_lp[c][ch] = 0;
                if (!m_lvl[c][ch]) begin
                    m_run[c][ch] = s ? m_run[c][ch] + 1 : 0;
                    if (m_run[c][ch] == stab(c)) begin
                        m_lvl[c][ch] = 1; m_pr[c][ch] = 1; m_hold[c][ch] = 0; m_run[c][ch] = 0;
                    end
                end else begin
                    if (!m_lng[c][ch]) m_hold[c][ch]++;
                    if (!m_lng[c][ch] && m_hold[c][ch] == longc(c)) begin
                        m_lng[c][ch] = 1; m_lp[c][ch] = 1; m_run[c][ch] = 0;
                    end else begin
                        m_run[c][ch] = !s ? m_run[c][ch] + 1 : 0;
                        if (m_run[c][ch] == stab(c)) begin
                            m_lvl[c][ch] = 0; m_rl[c][ch] = 1; m_lng[c][ch] = 0;
                            m_hold[c][ch] = 0; m_run[c][ch] = 0;
                        end
                    end
                end
            end
        end
        h2[0] = h1[0]; h2[1] = h1[1];
        h1[0] = btn_in[0]; h1[1] = btn_in[1];
    endtask

    function automatic logic [9:0] exp_vec(input int c);
        logic [1:0] b, p, r, lp, lh;
        for (int ch = 0; ch < 2; ch++) begin
            b[ch] = m_lvl[c][ch]; p[ch] = m_pr[c][ch]; r[ch] = m_rl[c][ch];
            lp[ch] = m_lp[c][ch]; lh[ch] = m_lng[c][ch];
        end
        return {b, p, r, lp, lh};
    endfunction

    task automatic compare_all();
        check_eq("dut_a", {22'd0, bo_a, pp_a, rp_a, lp_a, lh_a}, {22'd0, exp_vec(0)});
        check_eq("dut_b_inv", {22'd0, bo_b, pp_b, rp_b, lp_b, lh_b}, {22'd0, exp_vec(0)});
        check_eq("dut_c_s1", {22'd0, bo_c, pp_c, rp_c, lp_c, lh_c}, {22'd0, exp_vec(1)});
        check_eq("press_and_release", {30'd0, pp_a & rp_a}, 32'd0);
    endtask

    // Advance one clock, update the model, compare 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int lat;
    int cnt;
    int seg_left[2];

    initial begin
        rst = 1'b0;
        btn_in = 2'b00;
        model_reset();

        // Reset held while the inputs toggle: everything stays 0.
        for (int i = 0; i < 8; i++) begin
            tick();
            btn_in = 2'(i);
        end
        check_eq("reset_outputs", {22'd0, bo_a, pp_a, rp_a, lp_a, lh_a}, 32'd0);
        btn_in = 2'b00;
        ticks(3);
        rst = 1'b1;
        ticks(10);
        $display("txn reset/idle done");

        // Clean press on channel 0: level and strobe after 6 edges.
        btn_in = 2'b01;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bo_a[0]) begin lat = i; break; end
        end
        check_eq("press_latency", lat, 6);
        check_eq("press_pulse_at_rise", {31'd0, pp_a[0]}, 32'd1);
        $display("txn clean press latency=%0d", lat);

        // Keep holding: long press 10 cycles after the press strobe.
        lat = 99;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (lp_a[0]) begin lat = i; break; end
        end
        check_eq("long_latency", lat, 10);
        check_eq("long_held_set", {31'd0, lh_a[0]}, 32'd1);
        $display("txn long press latency=%0d", lat);

        // Release: strobe and long_held clear together after 6 edges.
        ticks(3);
        btn_in = 2'b00;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rp_a[0]) begin lat = i; break; end
        end
        check_eq("release_latency", lat, 6);
        check_eq("long_held_clear", {31'd0, lh_a[0]}, 32'd0);
        $display("txn release latency=%0d", lat);
        ticks(8);

        // Glitches: 3 high then low, then repeated 3-high/1-low bursts.
        btn_in = 2'b01; ticks(3);
        btn_in = 2'b00; ticks(6);
        for (int r = 0; r < 5; r++) begin
            btn_in = 2'b01; ticks(3);
            btn_in = 2'b00; ticks(1);
        end
        ticks(8);
        check_eq("glitch_no_press", {31'd0, bo_a[0]}, 32'd0);
        $display("txn glitch bursts filtered");

        // Release bounce during PRESSED: hold count continues uninterrupted.
        btn_in = 2'b01;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bo_a[0]) begin lat = i; break; end
        end
        check_eq("bounce_press_latency", lat, 6);
        cnt = 99;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 3) btn_in = 2'b00;
            if (i == 5) btn_in = 2'b01;
            if (lp_a[0]) begin cnt = i; break; end
        end
        check_eq("bounce_long_latency", cnt, 10);
        check_eq("bounce_level_kept", {31'd0, bo_a[0]}, 32'd1);
        $display("txn release bounce long=%0d", cnt);
        btn_in = 2'b00;
        ticks(12);

        // Reset while channel 0 is arming: no press afterwards.
        btn_in = 2'b01;
        ticks(4);
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("midop_reset_now", {22'd0, bo_a, pp_a, rp_a, lp_a, lh_a}, 32'd0);
        btn_in = 2'b00;
        ticks(2);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pp_a[0]) cnt++;
        end
        check_eq("midop_no_press", cnt, 0);
        check_eq("invert_idle_level", {30'd0, bo_b}, 32'd0);
        $display("txn mid-op reset and inverted idle");

        // Random per-channel segments: short glitches and long holds mixed.
        seg_left[0] = 0; seg_left[1] = 0;
        for (int i = 0; i < 2500; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (seg_left[ch] == 0) begin
                    btn_in[ch] = ~btn_in[ch];
                    seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                               : int'($urandom_range(1, 8));
                end
                seg_left[ch]--;
            end
            tick();
            if (pp_a != 0 || rp_a != 0 || lp_a != 0)
                $display("txn rnd cyc=%0d out=%b press=%b rel=%b long=%b", i, bo_a, pp_a, rp_a, lp_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_debounce
